result_writer: RTL and testbench
================================

// Module: result_writer
// PURPOSE
//  Downstream stage of the PE datapath. Accepts packed 4x8-bit result words, one per
//  resValid/resReady transfer, and writes them to output memory at consecutive addresses.
//  Each result word holds four 8-bit results.
//  A small FIFO absorbs memory backpressure. When memory is stalled, resReady deasserts
//  so the PE controller holds its result buffer. Signals done after a programmed word count.
// PARAMETERS
//  ADDR_W   8   output-memory address width; count width is also ADDR_W
//  DEPTH    4   FIFO entries, power of 2, >=2
// PORTS
//  clk        in   1       clock; all logic is rising-edge
//  rst        in   1       synchronous, active-low reset
//  start      in   1       1-cycle pulse; latches baseAddr/numWords; ignored while busy
//  baseAddr   in   ADDR_W  first write address
//  numWords   in   ADDR_W  number of words to write this run
//  resValid   in   1       result word offered (driven from the PE's rbFull)
//  resIn      in   32      {r0,r1,r2,r3}, r0 in [31:24]
//  resReady   out  1       word accepted when resValid&&resReady
//  memReady   in   1       memory accepts the write this cycle
//  memWrEn    out  1       write request
//  memAddr    out  ADDR_W  write address
//  memWrData  out  32      write data
//  busy       out  1       run in progress
//  done       out  1       1-cycle completion pulse
// BEHAVIOUR
//  - Reset (rst=0 at clk edge): state=IDLE, FIFO empty, counters 0.
//    Outputs after reset: memWrEn=0, memAddr=0, memWrData=0, resReady=0, busy=0, done=0.
//    Reset mid-run abandons the run; completed writes are not undone.
//  - FSM IDLE/RUN/FIN:
//    IDLE: start && numWords!=0 -> RUN, latching base, count, acc=0, wr=0.
//          start && numWords==0 -> FIN (no writes).
//    RUN:  -> FIN on the cycle the numWords-th write handshake completes.
//    FIN:  done=1 for exactly one cycle -> IDLE.
//  - busy=1 in RUN only. start while busy is ignored.
//  - resReady = RUN && !fifoFull && acc<numWords. fifoFull is registered: a pop in the
//    same cycle does not enable a push (no bypass).
//  - Words offered while resReady=0 are not consumed. The producer holds resIn stable
//    until the handshake.
//  - Write side: memWrEn = RUN && !fifoEmpty. memWrData = FIFO head (first-word
//    fall-through). memAddr = base + wr, truncated to ADDR_W bits, so it wraps mod 2^ADDR_W.
//    Once asserted, memWrEn/memAddr/memWrData stay stable until memReady=1.
//    On memWrEn&&memReady: pop, wr++.
//  - Latency: a word accepted at cycle n into an empty FIFO is presented at n+1.
//    Push and pop in the same cycle keep the occupancy unchanged.
//  - Ordering is strictly FIFO. Words beyond numWords are never accepted.
// CONFIGURATION
//  RESULT_WRITER_RELU_EN defined: each byte is treated as signed. Negative bytes become
//    0x00 on the push path (combinational, no added latency).
//  RESULT_WRITER_RELU_EN undefined: words pass through unmodified.
// STRUCTURE
//  - Shared package: FSM state encoding (IDLE/RUN/FIN), RES_W=32, BYTE_W=8.
//  - One sub-module: result_fifo. Synchronous FIFO with DEPTH/width parameters,
//    registered full/empty flags and a first-word-fall-through head.
// TESTING
//  1. base=0x10, numWords=4, memReady=1; resValid every cycle with 0x01020304+k.
//     -> writes to 0x10..0x13 in order; done pulses the cycle after the 4th write.
//  2. memReady=0 for 10 cycles, numWords=5, resValid held.
//     -> resReady drops after 4 accepts; after release, 5 words are written in order
//     with stable addr/data while stalled.
//  3. start with numWords=0 -> done=1 on the next cycle; memWrEn never asserted; busy stays 0.
//  4. rst=0 after 2 of 4 writes -> all outputs at reset values.
//     A new run then starts cleanly from the new baseAddr.
//  5. ADDR_W=8, base=0xFE, numWords=3 -> memAddr sequence 0xFE, 0xFF, 0x00.
//  6. resIn=0x807FFF01 -> memWrData=0x007F0001 with RESULT_WRITER_RELU_EN defined;
//     0x807FFF01 without it.

Source files
------------

// File: rtl/result_writer_pkg.sv
// Shared types and helpers for the result_writer slice: FSM encoding, word geometry
// and the per-byte ReLU used when RESULT_WRITER_RELU_EN is defined.
package result_writer_pkg;

  localparam int unsigned RES_W  = 32;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StFin  = 2'd2
  } state_t;

  // Each byte is a signed result; negative bytes clamp to zero.
  function automatic logic [RES_W-1:0] relu_word(input logic [RES_W-1:0] w);
    logic [RES_W-1:0] r;
    r = w;
    for (int i = 0; i < int'(RES_W / BYTE_W); i++) begin
      if (w[i*BYTE_W + BYTE_W - 1]) r[i*BYTE_W +: BYTE_W] = '0;
    end
    return r;
  endfunction

endpackage

// File: rtl/result_fifo.sv
// Synchronous FIFO with registered full/empty flags and a first-word-fall-through head.
// No bypass: a pop does not free a slot for a push in the same cycle.
module result_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             r_full;
  logic             r_empty;
  logic [PTR_W:0]   w_count_d;
  logic             w_push;
  logic             w_pop;

  assign w_push = push && !r_full;
  assign w_pop  = pop && !r_empty;

  always_comb begin
    w_count_d = r_count + {{PTR_W{1'b0}}, w_push} - {{PTR_W{1'b0}}, w_pop};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_d;
      r_full  <= (w_count_d == (PTR_W+1)'(DEPTH));
      r_empty <= (w_count_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= push_data;
  end

  assign full  = r_full;
  assign empty = r_empty;
  assign head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/result_writer.sv
// Writes packed 4x8-bit result words to consecutive output-memory addresses through a
// small FIFO; optional per-byte ReLU on the push path via RESULT_WRITER_RELU_EN.
module result_writer
  import result_writer_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] baseAddr,
  input  logic [ADDR_W-1:0] numWords,
  input  logic              resValid,
  input  logic [RES_W-1:0]  resIn,
  output logic              resReady,
  input  logic              memReady,
  output logic              memWrEn,
  output logic [ADDR_W-1:0] memAddr,
  output logic [RES_W-1:0]  memWrData,
  output logic              busy,
  output logic              done
);

  state_t            r_state;
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W-1:0] r_num;
  logic [ADDR_W-1:0] r_acc;
  logic [ADDR_W-1:0] r_wr;

  logic              w_full;
  logic              w_empty;
  logic [RES_W-1:0]  w_head;
  logic [RES_W-1:0]  w_push_data;
  logic              w_ready;
  logic              w_push;
  logic              w_wr_en;
  logic              w_pop;

  assign w_ready = (r_state == StRun) && !w_full && (r_acc < r_num);
  assign w_push  = resValid && w_ready;
  assign w_wr_en = (r_state == StRun) && !w_empty;
  assign w_pop   = w_wr_en && memReady;

`ifdef RESULT_WRITER_RELU_EN
  assign w_push_data = relu_word(resIn);
`else
  assign w_push_data = resIn;
`endif

  result_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (RES_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .push_data (w_push_data),
    .pop       (w_pop),
    .full      (w_full),
    .empty     (w_empty),
    .head      (w_head)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= StIdle;
      r_base  <= '0;
      r_num   <= '0;
      r_acc   <= '0;
      r_wr    <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (start) begin
            r_base  <= baseAddr;
            r_num   <= numWords;
            r_acc   <= '0;
            r_wr    <= '0;
            r_state <= (numWords != '0) ? StRun : StFin;
          end
        end
        StRun: begin
          if (w_push) r_acc <= r_acc + 1'b1;
          if (w_pop) begin
            r_wr <= r_wr + 1'b1;
            // The numWords-th write handshake ends the run.
            if (r_wr == r_num - 1'b1) r_state <= StFin;
          end
        end
        StFin:   r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

  assign resReady  = w_ready;
  assign memWrEn   = w_wr_en;
  assign memAddr   = r_base + r_wr;
  assign memWrData = w_wr_en ? w_head : '0;
  assign busy      = (r_state == StRun);
  assign done      = (r_state == StFin);

endmodule

// File: tb/tb_result_writer.sv
// Self-checking bench for result_writer: directed scenarios plus randomized runs checked
// against a transaction-level model (word lists, accept/write counters, FIFO occupancy).
module tb_result_writer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  baseAddr;
  logic [7:0]  numWords;
  logic        resValid;
  logic [31:0] resIn;
  logic        resReady;
  logic        memReady;
  logic        memWrEn;
  logic [7:0]  memAddr;
  logic [31:0] memWrData;
  logic        busy;
  logic        done;

  int n_tests = 0;
  int n_fail  = 0;

  result_writer #(
    .ADDR_W (8),
    .DEPTH  (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .baseAddr  (baseAddr),
    .numWords  (numWords),
    .resValid  (resValid),
    .resIn     (resIn),
    .resReady  (resReady),
    .memReady  (memReady),
    .memWrEn   (memWrEn),
    .memAddr   (memAddr),
    .memWrData (memWrData),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected memory word: bytes >= 0x80 are negative and clamp to 0 when ReLU is built in.
  function automatic logic [31:0] expect_word(input logic [31:0] w);
`ifdef RESULT_WRITER_RELU_EN
    int unsigned e;
    int unsigned v;
    e = 0;
    for (int k = 0; k < 4; k++) begin
      v = (int'(w) >> (8 * k)) & 255;
      if (v >= 128) v = 0;
      e = e | (v << (8 * k));
    end
    return 32'(e);
`else
    return w;
`endif
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, ".memWrEn"},   32'(memWrEn),  32'd0);
    chk({tag, ".memAddr"},   32'(memAddr),  32'd0);
    chk({tag, ".memWrData"}, memWrData,     32'd0);
    chk({tag, ".resReady"},  32'(resReady), 32'd0);
    chk({tag, ".busy"},      32'(busy),     32'd0);
    chk({tag, ".done"},      32'(done),     32'd0);
  endtask

  // mode: 0 random words, 1 incrementing 0x01020304+k, 2 fixed 0x807FFF01.
  task automatic run(input logic [7:0] b, input int n, input int mode, input int vpct,
                     input int rpct, input int stall, input int abort_at, output bit aborted);
    logic [31:0] words[$];
    int acc, wr, occ, cyc;
    bit v, r, rdy_exp;
    words = {};
    for (int k = 0; k < n; k++) begin
      case (mode)
        0:       words.push_back($urandom);
        1:       words.push_back(32'h01020304 + 32'(k));
        default: words.push_back(32'h807FFF01);
      endcase
    end
    start = 1'b1; baseAddr = b; numWords = 8'(n); resValid = 1'b0; memReady = 1'b0;
    tick();
    start = 1'b0;
    acc = 0; wr = 0; cyc = 0;
    while (wr < n && wr != abort_at && cyc < 2000) begin
      occ = acc - wr;
      rdy_exp = (occ < DEPTH) && (acc < n);
      chk("busy", 32'(busy), 32'd1);
      chk("done", 32'(done), 32'd0);
      chk("resReady", 32'(resReady), 32'(rdy_exp));
      chk("memWrEn", 32'(memWrEn), 32'(occ > 0));
      if (occ > 0) begin
        chk("memAddr", 32'(memAddr), 32'(8'(b + 8'(wr))));
        chk("memWrData", memWrData, expect_word(words[wr]));
      end
      v = ($urandom_range(99) < 32'(vpct));
      r = (cyc >= stall) && ($urandom_range(99) < 32'(rpct));
      resValid = v;
      resIn    = (acc < n) ? words[acc] : $urandom;
      memReady = r;
      // Starts during a run must have no effect.
      start    = ($urandom_range(7) == 0);
      baseAddr = 8'($urandom);
      numWords = 8'($urandom);
      if (v && rdy_exp) acc++;
      if (occ > 0 && r) wr++;
      cyc++;
      tick();
    end
    start = 1'b0; resValid = 1'b0; memReady = 1'b0;
    aborted = (wr == abort_at) && (wr < n);
    if (!aborted) begin
      chk("all_written", 32'(wr), 32'(n));
      chk("fin.done", 32'(done), 32'd1);
      chk("fin.busy", 32'(busy), 32'd0);
      chk("fin.memWrEn", 32'(memWrEn), 32'd0);
      chk("fin.resReady", 32'(resReady), 32'd0);
      tick();
      chk("idle.done", 32'(done), 32'd0);
      chk("idle.busy", 32'(busy), 32'd0);
      chk("idle.memWrEn", 32'(memWrEn), 32'd0);
    end
  endtask

  initial begin
    bit ab;
    rst = 1'b0; start = 1'b0; baseAddr = '0; numWords = '0;
    resValid = 1'b0; resIn = '0; memReady = 1'b0;
    tick(); tick(); tick();
    check_reset_outputs("reset");
    rst = 1'b1;
    tick();

    // 1: incrementing words, memory always ready, producer always valid.
    run(8'h10, 4, 1, 100, 100, 0, -1, ab);
    // 2: memory stalled for 10 cycles, producer held valid.
    run(8'h20, 5, 0, 100, 100, 10, -1, ab);
    // 3: zero-length run.
    run(8'h33, 0, 0, 100, 100, 0, -1, ab);
    // 4: reset after two of four writes, then a clean run from a new base.
    run(8'h40, 4, 0, 100, 100, 0, 2, ab);
    chk("abort_reached", 32'(ab), 32'd1);
    rst = 1'b0;
    tick();
    check_reset_outputs("midrun_reset");
    rst = 1'b1;
    tick();
    check_reset_outputs("after_reset");
    run(8'h80, 4, 0, 100, 100, 0, -1, ab);
    // 5: address wrap.
    run(8'hFE, 3, 1, 100, 100, 0, -1, ab);
    // 6: signed-byte pattern through the optional ReLU.
    run(8'h05, 1, 2, 100, 100, 0, -1, ab);

    for (int i = 0; i < 8; i++) begin
      run(8'($urandom), int'($urandom_range(20, 1)), 0, int'($urandom_range(90, 20)),
          int'($urandom_range(90, 20)), int'($urandom_range(5)), -1, ab);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
